// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and default sizes for the RAM8 arbiter
package ram_arb_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int AW_DEF = 3;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);
  // a lone requester wins; on a tie the one not granted last wins
  always_comb begin
    grant_valid = |req;
    grant_idx = (req == 2'b11) ? ~last : req[1];
  end
endmodule

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: round-robin sharing of one RAM8 bank between two requesters
module ram8_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [1:0]         we,
  input  logic [2*AW-1:0]    addr,
  input  logic [2*WIDTH-1:0] wdata,
  output logic [1:0]         ack,
  output logic [WIDTH-1:0]   rdata,
  output logic               busy,
  output logic [AW-1:0]      ram_addr,
  output logic [WIDTH-1:0]   ram_in,
  output logic               ram_load,
  input  logic [WIDTH-1:0]   ram_out
);
  state_t state;
  logic last;
  logic win;
  logic grant_valid;
  logic grant_idx;

  rr_pick2 u_pick (
    .req(req),
    .last(last),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );

  assign busy = (state != IDLE);

  // grant in IDLE, run the bank for one cycle in ACCESS, pulse ack in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      win <= 1'b0;
      ack <= '0;
      rdata <= '0;
      ram_addr <= '0;
      ram_in <= '0;
      ram_load <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (grant_valid) begin
          win <= grant_idx;
          last <= grant_idx;
          ram_addr <= grant_idx ? addr[2*AW-1:AW] : addr[AW-1:0];
          ram_in <= grant_idx ? wdata[2*WIDTH-1:WIDTH] : wdata[WIDTH-1:0];
          ram_load <= we[grant_idx];
          state <= ACCESS;
        end
        ACCESS: begin
          if (!ram_load) rdata <= ram_out;
          ram_load <= 1'b0;
          ack[win] <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter: directed checks of the RAM8 arbiter against a behavioural bank
module tb_ram8_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        busy;
  logic [2:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;
  logic [15:0] mem [8];
  int pass_cnt = 0;
  int total_cnt = 0;

  ram8_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .ram_addr(ram_addr), .ram_in(ram_in),
    .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // bank model: registers load on the rising edge, read is combinational
  always @(posedge clk) if (ram_load) mem[ram_addr] <= ram_in;
  assign ram_out = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic w, input logic [2:0] a, input logic [15:0] d);
    req[i] = 1'b1;
    we[i] = w;
    addr[i*3 +: 3] = a;
    wdata[i*16 +: 16] = d;
  endtask

  // one complete access by requester i; checks read data when it is a read
  task automatic run(input string tag, input int i, input logic w, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd);
    logic seen;
    seen = 1'b0;
    set_req(i, w, a, d);
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      seen = ack[i];
    end
    chk({tag, "_ack"}, {31'd0, seen}, 32'd1);
    if (!w) chk({tag, "_rdata"}, {16'd0, rdata}, {16'd0, exp_rd});
    req[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_load", {31'd0, ram_load}, 32'd0);
    chk("rst_addr", {29'd0, ram_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack", {30'd0, ack}, 32'd0);

    // single write then read
    set_req(0, 1'b1, 3'd3, 16'hBEEF);
    @(negedge clk);
    chk("wr_load", {31'd0, ram_load}, 32'd1);
    chk("wr_addr", {29'd0, ram_addr}, 32'd3);
    chk("wr_in", {16'd0, ram_in}, 32'h0000BEEF);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_noack", {30'd0, ack}, 32'd0);
    @(negedge clk);
    chk("wr_ack", {30'd0, ack}, 32'd1);
    chk("wr_load_off", {31'd0, ram_load}, 32'd0);
    req = '0;
    @(negedge clk);
    chk("wr_ack_pulse", {30'd0, ack}, 32'd0);
    @(negedge clk);
    run("rd3", 0, 1'b0, 3'd3, 16'h0, 16'hBEEF);
    chk("rdata_hold", {16'd0, rdata}, 32'h0000BEEF);

    // seed addr 1, then a tie straight after reset
    run("seed1", 1, 1'b1, 3'd1, 16'h5555, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 3'd1, 16'h0);
    set_req(1, 1'b1, 3'd1, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    chk("tie_ack0", {30'd0, ack}, 32'd1);
    chk("tie_old", {16'd0, rdata}, 32'h00005555);
    req[0] = 1'b0;
    @(negedge clk);
    chk("tie_gap1", {30'd0, ack}, 32'd0);
    @(negedge clk);
    chk("tie_gap2", {30'd0, ack}, 32'd0);
    @(negedge clk);
    chk("tie_ack1", {30'd0, ack}, 32'd2);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    run("tie_rd", 0, 1'b0, 3'd1, 16'h0, 16'h1234);

    // continuous contention from a fresh reset: 0,1,0,1,...
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 3'd3, 16'h0);
    set_req(1, 1'b0, 3'd1, 16'h0);
    for (int n = 1; n <= 23; n++) begin
      @(negedge clk);
      chk($sformatf("rr_%0d", n), {30'd0, ack},
          (n % 3 == 2) ? (((n / 3) % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
    end
    req = '0;
    repeat (3) @(negedge clk);

    // req1 rises while requester 0 is in ACCESS
    set_req(0, 1'b0, 3'd3, 16'h0);
    @(negedge clk);
    set_req(1, 1'b0, 3'd1, 16'h0);
    @(negedge clk);
    chk("busy_ack0", {30'd0, ack}, 32'd1);
    chk("busy_rd0", {16'd0, rdata}, 32'h0000BEEF);
    req[0] = 1'b0;
    @(negedge clk);
    chk("busy_g1", {30'd0, ack}, 32'd0);
    @(negedge clk);
    chk("busy_g2", {30'd0, ack}, 32'd0);
    @(negedge clk);
    chk("busy_ack1", {30'd0, ack}, 32'd2);
    chk("busy_rd1", {16'd0, rdata}, 32'h00001234);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // reset during the ACCESS cycle of a write
    run("seed5", 0, 1'b1, 3'd5, 16'h0001, 16'h0);
    set_req(0, 1'b1, 3'd5, 16'hFFFF);
    @(negedge clk);
    chk("mid_load", {31'd0, ram_load}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_load_drop", {31'd0, ram_load}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    req = '0;
    @(negedge clk);
    chk("mid_noack1", {30'd0, ack}, 32'd0);
    @(negedge clk);
    chk("mid_noack2", {30'd0, ack}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_noack3", {30'd0, ack}, 32'd0);
    run("mid_rd", 0, 1'b0, 3'd5, 16'h0, 16'h0001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
